// File: rtl/adc_buf_pkg.sv
// rtl/adc_buf_pkg.sv - shared constants, state encoding and log2 helper for the ADC buffer reader
package adc_buf_pkg;

  localparam int ADC_DATA_W    = 16;
  localparam int ADC_NUM_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  // Ceiling log2, never below 1 so a depth-2 buffer still gets a 1-bit address.
  function automatic int f_log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/adc_buf_reader_if.sv
// rtl/adc_buf_reader_if.sv - RAM read port and output stream bundle of the ADC buffer reader
interface adc_buf_reader_if
  import adc_buf_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W,
  parameter int ADDR_W = f_log2(ADC_NUM_WORDS)
) ();

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output mem_rd_en, mem_rd_addr, m_data, m_valid, m_last,
    input  mem_rd_data, m_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, m_data, m_valid, m_last,
    output mem_rd_data, m_ready
  );

endinterface

// File: rtl/adc_buf_skid.sv
// rtl/adc_buf_skid.sv - two-entry output buffer with valid/ready pop side
module adc_buf_skid
  import adc_buf_pkg::*;
#(
  parameter int DATA_W = ADC_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pop,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] slot [2];
  logic              head;
  logic              tail;

  // With one entry the tail is the other slot; when popping a full buffer the
  // freed head slot becomes the tail, which the same expression yields.
  assign tail      = head ^ count[0];
  assign out_data  = slot[head];
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      head    <= 1'b0;
      count   <= 2'd0;
    end else if (clr) begin
      head    <= 1'b0;
      count   <= 2'd0;
    end else begin
      if (push)
        slot[tail] <= push_data;
      if (pop)
        head <= ~head;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/adc_buf_reader.sv
// rtl/adc_buf_reader.sv - fetches circular-buffer words through the RAM read port into a framed stream
module adc_buf_reader
  import adc_buf_pkg::*;
#(
  parameter int DATA_W    = ADC_DATA_W,
  parameter int NUM_WORDS = ADC_NUM_WORDS,
  parameter int ADDR_W    = f_log2(NUM_WORDS),
  parameter int BURST_LEN = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W:0]   rd_ptr,
  output logic              empty,
  adc_buf_reader_if.master  bus
);

  localparam int            BCW     = f_log2(BURST_LEN);
  localparam logic [BCW-1:0] BC_LAST = BCW'(BURST_LEN - 1);
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [ADDR_W:0]   fet_ptr;
  logic              inflight;
  logic [BCW-1:0]    bcnt;
  logic              fetch;
  logic              pop;
  logic [1:0]        count;
  logic [1:0]        occ;

  adc_buf_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (inflight),
    .push_data (bus.mem_rd_data),
    .out_data  (bus.m_data),
    .out_valid (bus.m_valid),
    .out_ready (bus.m_ready),
    .pop       (pop),
    .count     (count)
  );

  // Occupancy credits a same-cycle pop so a new fetch can issue while the head
  // drains; without it the stream would bubble every third cycle.
  assign occ   = count + {1'b0, inflight} - {1'b0, pop};
  assign fetch = (state == RUN) && !flush && (fet_ptr != wr_ptr) && (occ < 2'd2);

  assign bus.mem_rd_en   = fetch;
  assign bus.mem_rd_addr = fet_ptr[ADDR_W-1:0];
  assign bus.m_last      = (bcnt == BC_LAST);
  assign empty           = (rd_ptr == wr_ptr) && (count == 2'd0) && !inflight;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = RUN;
      RUN:     if (!enable) state_nxt = DRAIN;
      DRAIN: begin
        if (enable)
          state_nxt = RUN;
        else if ((count == 2'd0) && !inflight)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fet_ptr  <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      bcnt     <= '0;
    end else if (flush) begin
      fet_ptr  <= wr_ptr;
      rd_ptr   <= wr_ptr;
      inflight <= 1'b0;
      bcnt     <= '0;
    end else begin
      inflight <= fetch;
      if (fetch)
        fet_ptr <= fet_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        bcnt   <= (bcnt == BC_LAST) ? '0 : bcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_buf_reader.sv
// tb/tb_adc_buf_reader.sv - scoreboard bench for the ADC buffer reader
module tb_adc_buf_reader;
  import adc_buf_pkg::*;

  localparam int DW = 16;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int BL = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          flush;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;

  always #5 clk = ~clk;

  adc_buf_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  adc_buf_reader #(.DATA_W(DW), .NUM_WORDS(NW), .BURST_LEN(BL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .flush  (flush),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .empty  (empty),
    .bus    (bus)
  );

  logic [DW-1:0] ram [NW];
  always @(posedge clk)
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_rd_addr];

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  int   bcnt = 0;
  int   cyc = 0;
  int   ahead = 0;
  int   fetch_cnt = 0;
  bit   bp_phase = 0;
  bit   log_addr = 0;
  int   addr_log[$];
  int   first_fetch = -1;
  int   first_valid = -1;
  int   first_xfer = -1;
  int   last_xfer = -1;
  bit   stall_prev = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put_word(input logic [DW-1:0] d);
    ram[wr_ptr[AW-1:0]] = d;
    exp_q.push_back('{data: d, last: (bcnt == BL-1)});
    bcnt   = (bcnt == BL-1) ? 0 : bcnt + 1;
    wr_ptr = wr_ptr + 1'b1;
  endtask

  task automatic wait_drain(input int budget, input bit rand_rdy);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      if (rand_rdy) bus.m_ready = ($urandom_range(0, 99) < 30);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n || flush) begin
      ahead = 0;
    end else begin
      if (bus.mem_rd_en) begin
        ahead++;
        fetch_cnt++;
      end
      if (bus.m_valid && bus.m_ready) ahead--;
      if (bp_phase) check("fetch_ahead", ahead <= 2, 1);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd_en && first_fetch < 0) first_fetch = cyc;
      if (bus.m_valid && first_valid < 0) first_valid = cyc;
      if (bus.mem_rd_en && log_addr) addr_log.push_back(int'(bus.mem_rd_addr));
      if (stall_prev && bus.m_valid) begin
        check("hold_data", bus.m_data, prev_data);
        check("hold_last", bus.m_last, prev_last);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("data", bus.m_data, e.data);
          check("last", bus.m_last, e.last);
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready && !flush;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int written;
    int f0;
    int f1;
    bit hit;
    bit last_en;
    logic [AW:0] occ_w;
    logic [AW:0] fl_wr;
    int exp_addr [4];

    rst_n       = 1'b0;
    enable      = 1'b0;
    flush       = 1'b0;
    wr_ptr      = 5;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_ptr",  rd_ptr, 0);
    check("rst_rd_en",   bus.mem_rd_en, 0);
    check("rst_rd_addr", bus.mem_rd_addr, 0);
    check("rst_valid",   bus.m_valid, 0);
    check("rst_data",    bus.m_data, 0);
    check("rst_last",    bus.m_last, 0);
    check("rst_state",   32'(dut.state), 32'(IDLE));
    wr_ptr = 0;
    #1;
    check("rst_empty", empty, 1);

    // Words sit in the buffer while enable is low: nothing may be fetched.
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) put_word(DW'(16'h100 + i));
    repeat (8) @(posedge clk);
    #1;
    check("idle_no_fetch", fetch_cnt, 0);
    check("idle_valid", bus.m_valid, 0);

    // Full 16-word stream at full rate.
    for (int i = 5; i < 16; i++) put_word(DW'(16'h100 + i));
    bus.m_ready = 1'b1;
    enable      = 1'b1;
    wait_drain(100, 0);
    check("lat_fetch_to_valid", first_valid - first_fetch, 2);
    check("stream_continuous", last_xfer - first_xfer, 15);
    check("stream_rd_ptr", rd_ptr, 16);
    check("stream_empty", empty, 1);

    // Random backpressure; the writer never overruns rd_ptr + NUM_WORDS.
    bp_phase = 1;
    written  = 0;
    for (int c = 0; c < 3000 && written < 64; c++) begin
      @(posedge clk); #1;
      bus.m_ready = ($urandom_range(0, 99) < 30);
      occ_w = wr_ptr - rd_ptr;
      if (occ_w < NW) begin
        put_word(DW'($urandom));
        written++;
      end
    end
    check("bp_written", written, 64);
    wait_drain(3000, 1);
    bp_phase    = 0;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rd_ptr", rd_ptr, wr_ptr);
    check("bp_empty", empty, 1);

    // Wrap-around: reposition both pointers to 14, then cross the MSB.
    wr_ptr = 14;
    flush  = 1'b1;
    exp_q.delete();
    bcnt = 0;
    @(posedge clk); #1;
    flush = 1'b0;
    check("wrap_start", rd_ptr, 14);
    log_addr = 1;
    addr_log.delete();
    for (int i = 0; i < 4; i++) put_word(DW'(16'h200 + i));
    wait_drain(100, 0);
    log_addr = 0;
    check("wrap_rd_ptr", rd_ptr, 18);
    check("wrap_naddr", addr_log.size(), 4);
    exp_addr = '{14, 15, 0, 1};
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check("wrap_addr", addr_log[i], exp_addr[i]);

    // Enable drop with one word buffered and one in flight.
    bus.m_ready = 1'b0;
    @(posedge clk); #1;
    f0 = fetch_cnt;
    put_word(16'h3A0);
    put_word(16'h3A1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_valid && n < 20);
    check("ed_valid", bus.m_valid, 1);
    check("ed_fetched", fetch_cnt - f0, 2);
    #1;
    enable = 1'b0;
    put_word(16'h3A2);
    put_word(16'h3A3);
    f1 = fetch_cnt;
    repeat (3) @(posedge clk);
    #1;
    bus.m_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ed_delivered", exp_q.size(), 2);
    repeat (10) @(posedge clk);
    #1;
    check("ed_no_fetch", fetch_cnt, f1);
    check("ed_state", 32'(dut.state), 32'(IDLE));
    check("ed_valid_low", bus.m_valid, 0);

    // Flush while a read is in flight and a handshake is happening.
    enable = 1'b1;
    for (int i = 0; i < 6; i++) put_word(DW'(16'h400 + i));
    n       = 0;
    hit     = 0;
    last_en = 0;
    while (!hit && n < 30) begin
      @(negedge clk);
      n++;
      hit     = bus.m_valid && bus.m_ready && last_en;
      last_en = bus.mem_rd_en;
    end
    check("fl_setup", hit, 1);
    #1;
    flush = 1'b1;
    fl_wr = wr_ptr;
    exp_q.delete();
    bcnt = 0;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_rd_ptr", rd_ptr, fl_wr);
    check("fl_valid", bus.m_valid, 0);
    check("fl_empty", empty, 1);
    repeat (6) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) put_word(DW'(16'h500 + i));
    wait_drain(100, 0);
    @(posedge clk); #1;
    check("end_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
